controller_poller: RTL

- Frame-synchronous sequencer and CPU register front-end sitting around controller_interface_m.
- On each frame_tick it drives controller_interface_m's start input for a fixed window, waits for the serial shift to settle, then samples both 8-bit controller_N_data_out words.
- Keeps held-button state and sticky "newly pressed" (rising-edge) flags per controller.
- Exposes both through a 4-register CPU read port; reading a flags register clears it.

---
 rtl/controller_poller.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/controller_poller.sv
// Frame-synchronous scan sequencer for controller_interface_m plus a 4-register
// CPU read port exposing held buttons and sticky newly-pressed flags.
module controller_poller #(
    parameter int START_CYCLES  = 9,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       clk_1,
    input  logic       rst,
    input  logic       frame_tick,
    output logic       start,
    input  logic [7:0] controller_1_data,
    input  logic [7:0] controller_2_data,
    input  logic [1:0] cpu_addr,
    input  logic       cpu_read,
    output logic [7:0] cpu_data,
    output logic       busy
);

    localparam int MAX_CYCLES = (START_CYCLES > SETTLE_CYCLES) ? START_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] START_LOAD  = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_SAMPLE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             pending_q, pending_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic [7:0]       held_1_q, held_1_d;
    logic [7:0]       held_2_q, held_2_d;
    logic [7:0]       pressed_1_q, pressed_1_d;
    logic [7:0]       pressed_2_q, pressed_2_d;
    logic [7:0]       cpu_data_q, cpu_data_d;
    logic             sample_s;
    logic [7:0]       edges_1_s, edges_2_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            pending_q   <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            held_1_q    <= 8'h00;
            held_2_q    <= 8'h00;
            pressed_1_q <= 8'h00;
            pressed_2_q <= 8'h00;
            cpu_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            pending_q   <= pending_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            held_1_q    <= held_1_d;
            held_2_q    <= held_2_d;
            pressed_1_q <= pressed_1_d;
            pressed_2_q <= pressed_2_d;
            cpu_data_q  <= cpu_data_d;
        end
    end

    // Next-state, window counter and 1-deep pending-tick logic.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick || pending_q) begin
                    state_d   = ST_START;
                    counter_d = START_LOAD;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (counter_q == '0) begin
                    state_d   = ST_SETTLE;
                    counter_d = SETTLE_LOAD;
                end else begin
                    counter_d = counter_q - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (counter_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    counter_d = counter_q - CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                counter_d = '0;
            end
        endcase
        // Ticks arriving mid-scan, including on the sample cycle, queue one rescan.
        if ((state_q != ST_IDLE) && frame_tick) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_d;
        end
    end

    // Registered FSM outputs derived from the upcoming state.
    always_comb begin
        start_d  = (state_d == ST_START);
        busy_d   = (state_d != ST_IDLE);
        sample_s = (state_q == ST_SAMPLE);
    end

    // Held/pressed capture and CPU read port with read-to-clear flags.
    always_comb begin
        edges_1_s   = controller_1_data & ~held_1_q;
        edges_2_s   = controller_2_data & ~held_2_q;
        held_1_d    = held_1_q;
        held_2_d    = held_2_q;
        pressed_1_d = pressed_1_q;
        pressed_2_d = pressed_2_q;
        cpu_data_d  = cpu_data_q;
        if (sample_s) begin
            held_1_d    = controller_1_data;
            held_2_d    = controller_2_data;
            pressed_1_d = pressed_1_q | edges_1_s;
            pressed_2_d = pressed_2_q | edges_2_s;
        end else begin
            held_1_d = held_1_q;
        end
        if (cpu_read) begin
            case (cpu_addr)
                2'd0: cpu_data_d = held_1_q;
                2'd1: cpu_data_d = held_2_q;
                2'd2: begin
                    cpu_data_d  = pressed_1_q;
                    // A clear racing a sample keeps only the edges seen in this sample.
                    pressed_1_d = sample_s ? edges_1_s : 8'h00;
                end
                2'd3: begin
                    cpu_data_d  = pressed_2_q;
                    pressed_2_d = sample_s ? edges_2_s : 8'h00;
                end
                default: cpu_data_d = cpu_data_q;
            endcase
        end else begin
            cpu_data_d = cpu_data_q;
        end
    end

    assign start    = start_q;
    assign busy     = busy_q;
    assign cpu_data = cpu_data_q;

endmodule
